// File: rtl/tri_bus_arbiter_if.sv
// Bus-side signal bundle for tri_bus_arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the
// drivers and gates: they raise requests and consume the enables.
interface tri_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = $clog2(N);

    logic [N-1:0]  iReq;    // per-driver level request
    logic [N-1:0]  oEna;    // one-hot (or zero) tri-state enables
    logic          oBusy;   // any enable high
    logic [OW-1:0] oOwner;  // index of granted driver, valid while oBusy

    modport master (
        input  iReq,
        output oEna,
        output oBusy,
        output oOwner
    );

    modport slave (
        output iReq,
        input  oEna,
        input  oBusy,
        input  oOwner
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving the enables of a bank of tri-state bus drivers.
// - The grant is held as a registered one-hot enable vector.
// - A hold limit (MAX_HOLD, 0 = unlimited) forces a handoff while other drivers wait.
// - Optional macro TRI_ARB_TURNAROUND_EN compiles in a one-cycle all-enables-low
//   TURN state on every release, so two drivers never overlap on the bus.
//   Without the macro, ownership passes back-to-back on a single edge.
module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    tri_bus_arbiter_if.master   bus
);
    localparam int OW = $clog2(N);
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1
`ifdef TRI_ARB_TURNAROUND_EN
        ,
        S_TURN  = 2'd2
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  ptr_q, ptr_d;       // index of the last granted driver
    logic [CW-1:0]  cnt_q, cnt_d;       // consecutive grant cycles of current owner
    logic [N-1:0]   ena_q, ena_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic           busy_q, busy_d;

    logic           grant_new;          // load a fresh winner on this edge
    logic           any_req;
    logic           own_req;
    logic           others_req;
    logic           hold_hit;
    logic           release_now;
    logic           win_found;
    logic [OW-1:0]  win_idx;
    logic [N-1:0]   win_onehot;

    // Request summaries relative to the current owner (ena_q is its one-hot mask).
    assign any_req    = |bus.iReq;
    assign own_req    = |(bus.iReq & ena_q);
    assign others_req = |(bus.iReq & ~ena_q);
    assign hold_hit   = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD)) && others_req;
    assign release_now = !own_req || hold_hit;

    // Round-robin search: first requester at or after ptr+1, wrapping modulo N.
    // When the owner releases, ptr equals the owner, so the search naturally starts
    // just past it and reaches the owner itself only last.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!win_found && bus.iReq[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    // One-hot decode of the winning index.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_win_dec
            assign win_onehot[gi] = (win_idx == OW'(gi));
        end
    endgenerate

    // State and registered outputs; async reset floats the bus immediately.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            ptr_q   <= OW'(N - 1);
            cnt_q   <= '0;
            ena_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state selection and the decision to load a new winner.
    always_comb begin
        state_d   = state_q;
        grant_new = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d   = S_GRANT;
                    grant_new = 1'b1;
                end
            end
`ifdef TRI_ARB_TURNAROUND_EN
            S_TURN: begin
                if (any_req) begin
                    state_d   = S_GRANT;
                    grant_new = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
`endif
            S_GRANT: begin
                if (release_now) begin
`ifdef TRI_ARB_TURNAROUND_EN
                    state_d = S_TURN;
`else
                    if (any_req) begin
                        state_d   = S_GRANT;
                        grant_new = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        ena_d   = ena_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = (state_d == S_GRANT);
        if (state_d != S_GRANT) begin
            ena_d = '0;
            cnt_d = '0;
        end else if (grant_new) begin
            ena_d   = win_onehot;
            owner_d = win_idx;
            ptr_d   = win_idx;
            cnt_d   = CW'(1);
        end else if ((MAX_HOLD != 0) && (cnt_q != CW'(MAX_HOLD))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign bus.oEna   = ena_q;
    assign bus.oOwner = owner_q;
    assign bus.oBusy  = busy_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed and random checks for tri_bus_arbiter (N=4, MAX_HOLD=8).
// Adapts its expected sequences to TRI_ARB_TURNAROUND_EN.
module tb_tri_bus_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter_if #(.N(N)) bus_if ();

    tri_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus_if)
    );

    // Hold reset for two cycles with the given requests, release on a falling edge.
    task automatic apply_reset(input logic [3:0] req);
        rst = 1'b1;
        bus_if.iReq = req;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset(4'b1111);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ena: got %b want 0000", bus_if.oEna);
        end
        n_checks++;
        if (bus_if.oBusy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus_if.oBusy);
        end
        n_checks++;
        if (bus_if.oOwner !== 2'd0) begin
            n_fail++; $display("FAIL reset_owner: got %0d want 0", bus_if.oOwner);
        end
        n_checks++;
        if (int'(dut.cnt_q) != 0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0001 || bus_if.oOwner !== 2'd0 || bus_if.oBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: got ena=%b owner=%0d busy=%b want ena=0001 owner=0 busy=1",
                     bus_if.oEna, bus_if.oOwner, bus_if.oBusy);
        end
        $display("test_reset done: ena=%b owner=%0d", bus_if.oEna, bus_if.oOwner);
    endtask

    task automatic test_turnaround;
        apply_reset(4'b1111);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus_if.oEna !== 4'b0001) begin
                n_fail++; $display("FAIL ta_hold c%0d: got %b want 0001", c, bus_if.oEna);
            end
        end
        bus_if.iReq = 4'b1110;
`ifdef TRI_ARB_TURNAROUND_EN
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0000 || bus_if.oBusy !== 1'b0) begin
            n_fail++; $display("FAIL ta_gap: got ena=%b busy=%b want 0000/0", bus_if.oEna, bus_if.oBusy);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0010 || bus_if.oOwner !== 2'd1) begin
            n_fail++; $display("FAIL ta_next: got ena=%b owner=%0d want 0010 owner=1", bus_if.oEna, bus_if.oOwner);
        end
        $display("test_turnaround done: ena=%b", bus_if.oEna);
    endtask

    task automatic test_hold_limit;
        logic [3:0] exp;
`ifdef TRI_ARB_TURNAROUND_EN
        int total = 26;
`else
        int total = 24;
`endif
        apply_reset(4'b0101);
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
`ifdef TRI_ARB_TURNAROUND_EN
            if (c <= 8)       exp = 4'b0001;
            else if (c == 9)  exp = 4'b0000;
            else if (c <= 17) exp = 4'b0100;
            else if (c == 18) exp = 4'b0000;
            else              exp = 4'b0001;
`else
            if (c <= 8)       exp = 4'b0001;
            else if (c <= 16) exp = 4'b0100;
            else              exp = 4'b0001;
`endif
            n_checks++;
            if (bus_if.oEna !== exp) begin
                n_fail++; $display("FAIL hold c%0d: got %b want %b", c, bus_if.oEna, exp);
            end
        end
        $display("test_hold_limit done after %0d cycles", total);
    endtask

    task automatic test_single_requester;
        apply_reset(4'b1000);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus_if.oEna !== 4'b1000 || bus_if.oOwner !== 2'd3) begin
                n_fail++; $display("FAIL single c%0d: got ena=%b owner=%0d want 1000 owner=3", c, bus_if.oEna, bus_if.oOwner);
            end
        end
        n_checks++;
        if (int'(dut.cnt_q) != MAX_HOLD) begin
            n_fail++; $display("FAIL single_cnt: got %0d want %0d", dut.cnt_q, MAX_HOLD);
        end
        $display("test_single_requester done: cnt=%0d", dut.cnt_q);
    endtask

    task automatic test_release_and_wrap;
        apply_reset(4'b0000);
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0000 || bus_if.oBusy !== 1'b0) begin
            n_fail++; $display("FAIL idle: got ena=%b busy=%b want 0000/0", bus_if.oEna, bus_if.oBusy);
        end
        bus_if.iReq = 4'b0010;
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0010 || bus_if.oOwner !== 2'd1) begin
            n_fail++; $display("FAIL grant1: got ena=%b owner=%0d want 0010 owner=1", bus_if.oEna, bus_if.oOwner);
        end
        bus_if.iReq = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0000 || bus_if.oBusy !== 1'b0) begin
            n_fail++; $display("FAIL release: got ena=%b busy=%b want 0000/0", bus_if.oEna, bus_if.oBusy);
        end
        // Both 0 and 3 request; the last owner was 1, so the search from 2 finds 3.
        bus_if.iReq = 4'b1001;
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b1000 || bus_if.oOwner !== 2'd3) begin
            n_fail++; $display("FAIL rr_pick: got ena=%b owner=%0d want 1000 owner=3", bus_if.oEna, bus_if.oOwner);
        end
        bus_if.iReq = 4'b0001;
`ifdef TRI_ARB_TURNAROUND_EN
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_gap: got %b want 0000", bus_if.oEna);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0001 || bus_if.oOwner !== 2'd0) begin
            n_fail++; $display("FAIL wrap: got ena=%b owner=%0d want 0001 owner=0", bus_if.oEna, bus_if.oOwner);
        end
        $display("test_release_and_wrap done: ena=%b", bus_if.oEna);
    endtask

    task automatic test_async_reset;
        apply_reset(4'b0100);
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0100) begin
            n_fail++; $display("FAIL async_pre: got %b want 0100", bus_if.oEna);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus_if.oEna !== 4'b0000 || bus_if.oBusy !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: got ena=%b busy=%b want 0000/0", bus_if.oEna, bus_if.oBusy);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_if.iReq = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (bus_if.oEna !== 4'b0000) begin
            n_fail++; $display("FAIL async_post: got %b want 0000", bus_if.oEna);
        end
        $display("test_async_reset done: ena=%b", bus_if.oEna);
    endtask

    task automatic test_random;
        int wait_cnt [N];
        int bound;
        logic [3:0] req;
        bound = (N - 1) * (MAX_HOLD + 1);
        for (int j = 0; j < N; j++) wait_cnt[j] = 0;
        apply_reset(4'b0000);
        req = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            n_checks++;
            if (!$onehot0(bus_if.oEna)) begin
                n_fail++; $display("FAIL rnd_onehot c%0d: got %b want one-hot or zero", c, bus_if.oEna);
            end
            n_checks++;
            if (bus_if.oBusy !== (|bus_if.oEna)) begin
                n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", c, bus_if.oBusy, |bus_if.oEna);
            end
            if (bus_if.oBusy === 1'b1) begin
                n_checks++;
                if (bus_if.oEna !== (4'b0001 << bus_if.oOwner)) begin
                    n_fail++; $display("FAIL rnd_owner c%0d: got owner=%0d ena=%b want matching", c, bus_if.oOwner, bus_if.oEna);
                end
            end
            for (int j = 0; j < N; j++) begin
                if (req[j] && !bus_if.oEna[j]) wait_cnt[j]++;
                else                           wait_cnt[j] = 0;
                if (wait_cnt[j] > bound) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rnd_starve c%0d drv%0d: got wait %0d want <= %0d", c, j, wait_cnt[j], bound);
                    wait_cnt[j] = 0;
                end
            end
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(15) == 0) req[j] = ~req[j];
            end
            bus_if.iReq = req;
        end
        $display("test_random done: 10000 cycles");
    endtask

    initial begin
        bus_if.iReq = 4'b0000;
        test_reset();
        test_turnaround();
        test_hold_limit();
        test_single_requester();
        test_release_and_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
